ext_pipe: RTL and testbench
===========================

EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter W, default 32, result/load-word width; legal values 32 and 64 only.
REQ-002 SHALL have parameter IMM_W, default 16, immediate width; 1 <= IMM_W < W.
REQ-003 SHALL derive OFF_W = log2(W/8), the byte-offset width (2 for W=32).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous squash of all in-flight entries.
REQ-007 SHALL have port in_valid, input, 1, upstream entry offered.
REQ-008 SHALL have port in_ready, output, 1, entry accepted when in_valid && in_ready.
REQ-009 SHALL have port ExtOp, input, 3, operation select per REQ-014.
REQ-010 SHALL have port Imm, input, IMM_W, immediate operand.
REQ-011 SHALL have port LoadWord, input, W, raw memory word.
REQ-012 SHALL have port AddrLo, input, OFF_W, byte offset of the load.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1) and Result (output, W); transfer when both valid and ready are high.

Function
REQ-014 SHALL encode ExtOp: 000 sign-extend Imm; 001 zero-extend Imm; 010 Imm in bits [W-1:W-IMM_W], lower bits 0; 011 LB signed; 100 LBU; 101 LH signed; 110 LHU; 111 full word pass.
REQ-015 SHALL select the byte lane as LoadWord[8*AddrLo +: 8] and the halfword lane as LoadWord[16*AddrLo[OFF_W-1:1] +: 16], little-endian.
REQ-016 SHALL be a two-stage pipeline: S1 registers the operands; S2 computes and registers Result.
REQ-017 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high.
REQ-018 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-019 SHALL advance S2 when !S2.valid || out_ready, and S1 into S2 under the same condition.
REQ-020 SHALL drive in_ready = !S1.valid || S1-advance, combinationally, with no dependence on in_valid.
REQ-021 SHALL hold Result and out_valid stable while out_valid && !out_ready; no entry is lost or duplicated.
REQ-022 SHALL clear both valid bits on the edge where flush=1; an offer on that same edge is dropped; flush has priority over accept and advance.
REQ-023 SHALL leave Result data unchanged on flush; only the valid bits clear.
REQ-024 SHALL ignore the unused operand of each mode (LoadWord/AddrLo for 000-010, Imm for 011-111).

Reset
REQ-025 SHALL, while reset=1 at a clock edge, clear S1.valid, S2.valid and Result to 0 and ignore in_valid and flush.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-027 SHALL abort any in-flight entry when reset is asserted mid-operation; that entry is never presented.

Configuration
REQ-028 SHALL honour macro EXT_ALIGN_CHK_EN: when defined, add output port Misalign (1 bit), registered alongside Result.
REQ-029 SHALL, with EXT_ALIGN_CHK_EN defined, set Misalign=1 and Result=0 for ExtOp 101/110 with AddrLo[0]=1 and for ExtOp 111 with AddrLo!=0; otherwise Misalign=0.
REQ-030 SHALL, without EXT_ALIGN_CHK_EN, omit Misalign, ignore AddrLo[0] for halfwords and ignore AddrLo for ExtOp 111.

Verification
REQ-031 SHALL cover: W=32, ExtOp=000, Imm=16'h8001 -> Result 32'hFFFF_8001 two cycles after acceptance; ExtOp=001 same Imm -> 32'h0000_8001; ExtOp=010 -> 32'h8001_0000.
REQ-032 SHALL cover: LoadWord=32'h80FF_7F01, AddrLo=2, ExtOp=011 -> 32'hFFFF_FFFF; ExtOp=100 -> 32'h0000_00FF; AddrLo=2, ExtOp=101 -> 32'hFFFF_80FF; ExtOp=110 -> 32'h0000_80FF.
REQ-033 SHALL cover: 8 back-to-back entries with out_ready held 0 for cycles 3-6 -> in_ready drops once both stages are full, all 8 results in order, none duplicated.
REQ-034 SHALL cover: flush asserted together with an accepted offer while 2 entries are in flight -> out_valid=0 next cycle, no result for any of the 3 entries.
REQ-035 SHALL cover: reset asserted with S2 stalled -> out_valid=0, Result=0 next cycle; in_ready=1 after release.
REQ-036 SHALL cover, with EXT_ALIGN_CHK_EN: ExtOp=101, AddrLo=1 -> Misalign=1, Result=0; W=64, ExtOp=111, AddrLo=0 -> Misalign=0, Result=LoadWord.

Source files
------------

// File: rtl/ext_pipe_if.sv
// Handshake/operand bundle for ext_pipe: upstream offer channel plus downstream result channel.
// Misalign is present only when EXT_ALIGN_CHK_EN is defined.
interface ext_pipe_if #(
  parameter int W     = 32,
  parameter int IMM_W = 16
);
  localparam int OFF_W = $clog2(W / 8);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ExtOp;
  logic [IMM_W-1:0] Imm;
  logic [W-1:0]     LoadWord;
  logic [OFF_W-1:0] AddrLo;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     Result;
`ifdef EXT_ALIGN_CHK_EN
  logic             Misalign;
`endif

  modport master (
    output in_valid, ExtOp, Imm, LoadWord, AddrLo, out_ready,
    input  in_ready, out_valid, Result
`ifdef EXT_ALIGN_CHK_EN
    , input Misalign
`endif
  );

  modport slave (
    input  in_valid, ExtOp, Imm, LoadWord, AddrLo, out_ready,
    output in_ready, out_valid, Result
`ifdef EXT_ALIGN_CHK_EN
    , output Misalign
`endif
  );
endinterface

// File: rtl/ext_pipe.sv
// Two-stage immediate/load-data extension pipeline with valid/ready flow control.
// Optional alignment checking (Misalign output) is enabled by defining EXT_ALIGN_CHK_EN.
module ext_pipe #(
  parameter int W     = 32,
  parameter int IMM_W = 16
) (
  input logic        clk,
  input logic        reset,
  input logic        flush,
  ext_pipe_if.slave  bus
);
  localparam int OFF_W = $clog2(W / 8);

  typedef enum logic [2:0] {
    OP_SEXT = 3'b000,
    OP_ZEXT = 3'b001,
    OP_HIGH = 3'b010,
    OP_LB   = 3'b011,
    OP_LBU  = 3'b100,
    OP_LH   = 3'b101,
    OP_LHU  = 3'b110,
    OP_WORD = 3'b111
  } ext_op_e;

  // Stage 1: registered operands
  logic             s1_valid;
  ext_op_e          s1_op;
  logic [IMM_W-1:0] s1_imm;
  logic [W-1:0]     s1_word;
  logic [OFF_W-1:0] s1_addr;

  // Stage 2: registered result
  logic             s2_valid;
  logic [W-1:0]     result;

  logic             advance;
  logic             s1_open;
  logic [7:0]       b_lane;
  logic [15:0]      h_lane;
  logic [W-1:0]     ext_val;
  logic             bad_align;

  // Both stages move together; S1 may refill in the same cycle it drains.
  assign advance = !s2_valid || bus.out_ready;
  assign s1_open = !s1_valid || advance;

  assign bus.in_ready  = s1_open;
  assign bus.out_valid = s2_valid;
  assign bus.Result    = result;

  assign b_lane = s1_word[{s1_addr, 3'b000} +: 8];
  assign h_lane = s1_word[{s1_addr[OFF_W-1:1], 4'b0000} +: 16];

`ifdef EXT_ALIGN_CHK_EN
  logic misalign;
  assign bus.Misalign = misalign;
  assign bad_align = ((s1_op == OP_LH || s1_op == OP_LHU) && s1_addr[0]) ||
                     (s1_op == OP_WORD && s1_addr != '0);
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives ext_val and no latch is inferred.
    ext_val = '0;
    unique case (s1_op)
      OP_SEXT: ext_val = {{(W-IMM_W){s1_imm[IMM_W-1]}}, s1_imm};
      OP_ZEXT: ext_val = {{(W-IMM_W){1'b0}}, s1_imm};
      OP_HIGH: ext_val = {s1_imm, {(W-IMM_W){1'b0}}};
      OP_LB:   ext_val = {{(W-8){b_lane[7]}}, b_lane};
      OP_LBU:  ext_val = {{(W-8){1'b0}}, b_lane};
      OP_LH:   ext_val = {{(W-16){h_lane[15]}}, h_lane};
      OP_LHU:  ext_val = {{(W-16){1'b0}}, h_lane};
      OP_WORD: ext_val = s1_word;
      default: ext_val = '0;
    endcase
    if (bad_align) ext_val = '0;
  end

  // Control state and result register; flush clears valids only, leaving data intact.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      result   <= '0;
`ifdef EXT_ALIGN_CHK_EN
      misalign <= 1'b0;
`endif
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= ext_val;
`ifdef EXT_ALIGN_CHK_EN
          misalign <= bad_align;
`endif
        end
      end
      if (s1_open) s1_valid <= bus.in_valid;
    end
  end

  // NOTE: operand registers carry no reset; they are only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush && s1_open && bus.in_valid) begin
      s1_op   <= ext_op_e'(bus.ExtOp);
      s1_imm  <= bus.Imm;
      s1_word <= bus.LoadWord;
      s1_addr <= bus.AddrLo;
    end
  end
endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe (W=32); adds misalign and W=64 cases when
// EXT_ALIGN_CHK_EN is defined.
module tb_ext_pipe;
  logic clk;
  logic reset;
  logic flush;
  int   total;
  int   bad;

  ext_pipe_if #(.W(32), .IMM_W(16)) bus ();
  ext_pipe #(.W(32), .IMM_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

`ifdef EXT_ALIGN_CHK_EN
  ext_pipe_if #(.W(64), .IMM_W(16)) bus64 ();
  ext_pipe #(.W(64), .IMM_W(16)) dut64 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus64)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Offer one entry with out_ready high; check it appears exactly two edges after acceptance.
  task automatic send_one(input string tag, input logic [2:0] op, input logic [15:0] imm,
                          input logic [31:0] word, input logic [1:0] addr,
                          input logic [31:0] exp);
    @(negedge clk);
    bus.ExtOp     = op;
    bus.Imm       = imm;
    bus.LoadWord  = word;
    bus.AddrLo    = addr;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    #1;
    check({tag, "_rdy"}, bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_early"}, bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"}, bus.out_valid, 1);
    check(tag, bus.Result, exp);
  endtask

  logic [2:0]  b2b_op  [8];
  logic [15:0] b2b_imm [8];
  logic [31:0] b2b_exp [8];
  int          sent;
  int          recv;
  logic        saw_stall;
  logic        fire_in;
  logic        fire_out;
  logic        leaked;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ExtOp     = 3'b000;
    bus.Imm       = '0;
    bus.LoadWord  = '0;
    bus.AddrLo    = '0;
`ifdef EXT_ALIGN_CHK_EN
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b1;
    bus64.ExtOp     = 3'b000;
    bus64.Imm       = '0;
    bus64.LoadWord  = '0;
    bus64.AddrLo    = '0;
`endif

    b2b_op  = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
    b2b_imm = '{16'h0001, 16'h8002, 16'h7FFF, 16'hFFFE, 16'h1234, 16'h8765, 16'h0F0F, 16'hF0F0};
    b2b_exp = '{32'h0000_0001, 32'hFFFF_8002, 32'h0000_7FFF, 32'hFFFF_FFFE,
                32'h0000_1234, 32'hFFFF_8765, 32'h0000_0F0F, 32'hFFFF_F0F0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.Result, 0);

    // Immediate modes; LoadWord/AddrLo carry junk that must be ignored
    send_one("sext",  3'b000, 16'h8001, 32'hDEAD_BEEF, 2'd3, 32'hFFFF_8001);
    send_one("zext",  3'b001, 16'h8001, 32'hDEAD_BEEF, 2'd1, 32'h0000_8001);
    send_one("high",  3'b010, 16'h8001, 32'hDEAD_BEEF, 2'd2, 32'h8001_0000);
    // Load modes; Imm carries junk that must be ignored
    send_one("lb2",   3'b011, 16'hFFFF, 32'h80FF_7F01, 2'd2, 32'hFFFF_FFFF);
    send_one("lbu2",  3'b100, 16'hFFFF, 32'h80FF_7F01, 2'd2, 32'h0000_00FF);
    send_one("lh2",   3'b101, 16'hFFFF, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF);
    send_one("lhu2",  3'b110, 16'hFFFF, 32'h80FF_7F01, 2'd2, 32'h0000_80FF);
    send_one("lb3",   3'b011, 16'h0000, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80);
    send_one("lb1",   3'b011, 16'h0000, 32'h80FF_7F01, 2'd1, 32'h0000_007F);
    send_one("lh0",   3'b101, 16'h0000, 32'h80FF_7F01, 2'd0, 32'h0000_7F01);
    send_one("word0", 3'b111, 16'h1234, 32'h80FF_7F01, 2'd0, 32'h80FF_7F01);
`ifdef EXT_ALIGN_CHK_EN
    send_one("lh3",   3'b101, 16'h0000, 32'h80FF_7F01, 2'd3, 32'h0000_0000);
    check("lh3_mis", bus.Misalign, 1);
    send_one("lh1",   3'b101, 16'h0000, 32'h80FF_7F01, 2'd1, 32'h0000_0000);
    check("lh1_mis", bus.Misalign, 1);
    send_one("word1", 3'b111, 16'h0000, 32'h80FF_7F01, 2'd1, 32'h0000_0000);
    check("word1_mis", bus.Misalign, 1);
    send_one("lh2b",  3'b101, 16'h0000, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF);
    check("lh2b_mis", bus.Misalign, 0);
`else
    send_one("lh3",   3'b101, 16'h0000, 32'h80FF_7F01, 2'd3, 32'hFFFF_80FF);
    send_one("word1", 3'b111, 16'h0000, 32'h80FF_7F01, 2'd1, 32'h80FF_7F01);
`endif

    // Back-to-back stream with a downstream stall in cycles 3..6
    @(negedge clk);
    sent = 0;
    recv = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      if (c != 0) @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 6);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.ExtOp = b2b_op[sent];
        bus.Imm   = b2b_imm[sent];
      end
      #1;
      if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        check($sformatf("b2b_%0d", recv), bus.Result, b2b_exp[recv]);
        recv++;
      end
      @(posedge clk);
      if (fire_in) sent++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("b2b_count", recv, 8);
    check("b2b_stall", saw_stall, 1);
    leaked = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.out_valid) leaked = 1'b1;
      @(negedge clk);
    end
    check("b2b_nodup", leaked, 0);

    // Flush with two entries in flight plus a simultaneous accepted offer
    bus.ExtOp    = 3'b000;
    bus.Imm      = 16'h8001;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ExtOp = 3'b001;
    bus.Imm   = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    check("fl_pre_vld", bus.out_valid, 1);
    check("fl_pre_res", bus.Result, 32'hFFFF_8001);
    bus.ExtOp = 3'b010;
    bus.Imm   = 16'h2222;
    flush     = 1'b1;
    #1;
    check("fl_offer_rdy", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_res_kept", bus.Result, 32'hFFFF_8001);
    leaked = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.out_valid) leaked = 1'b1;
      @(negedge clk);
    end
    check("fl_no_result", leaked, 0);

    // Reset while S2 is stalled
    bus.out_ready = 1'b0;
    bus.ExtOp     = 3'b001;
    bus.Imm       = 16'h00AA;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("st_vld", bus.out_valid, 1);
    check("st_res", bus.Result, 32'h0000_00AA);
    @(posedge clk);
    @(negedge clk);
    check("st_hold_vld", bus.out_valid, 1);
    check("st_hold_res", bus.Result, 32'h0000_00AA);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rs_out_valid", bus.out_valid, 0);
    check("rs_result", bus.Result, 0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rs_in_ready", bus.in_ready, 1);
    leaked = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) leaked = 1'b1;
    end
    check("rs_aborted", leaked, 0);

`ifdef EXT_ALIGN_CHK_EN
    // 64-bit full-word pass, aligned
    @(negedge clk);
    bus64.ExtOp     = 3'b111;
    bus64.LoadWord  = 64'h0123_4567_89AB_CDEF;
    bus64.AddrLo    = 3'd0;
    bus64.out_ready = 1'b1;
    bus64.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus64.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w64_vld", bus64.out_valid, 1);
    check("w64_res", bus64.Result, 64'h0123_4567_89AB_CDEF);
    check("w64_mis", bus64.Misalign, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
